// File: rtl/uart_pkg.sv
// Shared UART types used by the bridge and the PHY modules.
//   uart_byte_t : one UART data byte
//   BYTE_W      : width of a UART data byte
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with first-word fall-through read.
// Holds the full 2^DEPTH_LOG2 entries: pointers carry one extra wrap bit.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   push, push_data     : write request and byte (ignored while full)
//   pop                 : read request (ignored while empty)
//   pop_data            : byte at head, valid whenever empty is low
//   full, empty, count  : status and occupancy
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  uart_byte_t          push_data,
  input  logic                pop,
  output uart_byte_t          pop_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);

  uart_byte_t          mem [DEPTH];
  logic [DEPTH_LOG2:0] head;
  logic [DEPTH_LOG2:0] tail;
  logic                do_push;
  logic                do_pop;

  assign empty    = (head == tail);
  assign full     = (head[DEPTH_LOG2-1:0] == tail[DEPTH_LOG2-1:0]) &&
                    (head[DEPTH_LOG2] != tail[DEPTH_LOG2]);
  assign count    = tail - head;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[head[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_ONE;
      if (do_pop)  head <= head + PTR_ONE;
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_stream_bridge.sv
// Buffered bridge between the UART RX/TX PHYs and the core byte streams.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   phy_reset                      : reset forwarded to both PHYs
//   rx_data, rx_strobe             : byte from the RX PHY
//   tx_data, tx_start, tx_busy     : byte to the TX PHY and its status
//   cts_n, rts_n                   : hardware flow control (active low)
//   in_data/in_valid/in_ready      : core -> TX stream
//   out_data/out_valid/out_ready   : RX -> core stream
//   rx_count, tx_count             : FIFO occupancy
//   rx_overflow, overflow_clear    : sticky dropped-byte flag and its clear
module uart_stream_bridge
  import uart_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 10,
  parameter int TX_DEPTH_LOG2 = 10,
  parameter int RTS_MARGIN    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   phy_reset,
  input  uart_byte_t             rx_data,
  input  logic                   rx_strobe,
  output uart_byte_t             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  input  logic                   cts_n,
  output logic                   rts_n,
  input  uart_byte_t             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output uart_byte_t             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RX_DEPTH_LOG2:0] rx_count,
  output logic [TX_DEPTH_LOG2:0] tx_count,
  output logic                   rx_overflow,
  input  logic                   overflow_clear
);

  localparam logic [RX_DEPTH_LOG2:0] RX_CAP =
    (RX_DEPTH_LOG2 + 1)'(1 << RX_DEPTH_LOG2);
  localparam logic [RX_DEPTH_LOG2:0] RTS_LIMIT = (RX_DEPTH_LOG2 + 1)'(RTS_MARGIN);

  logic                   rx_full;
  logic                   rx_empty;
  logic                   tx_full;
  logic                   tx_empty;
  uart_byte_t             tx_head;
  logic                   tx_push;
  logic                   issue;
  logic [1:0]             cts_sync;
  logic [RX_DEPTH_LOG2:0] rx_free;

  assign phy_reset = reset;
  assign out_valid = !rx_empty;
  assign in_ready  = !tx_full && !reset;
  assign tx_push   = in_valid && in_ready;
  assign rx_free   = RX_CAP - rx_count;

  // The !tx_start term gives the PHY one cycle to raise tx_busy.
  assign issue = !tx_empty && !tx_busy && !cts_sync[1] && !tx_start && !reset;

  uart_sync_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_strobe),
    .push_data (rx_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  uart_sync_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (in_data),
    .pop       (issue),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // cts_n is asynchronous to clk; resets to "not clear".
  always_ff @(posedge clk) begin
    if (reset) cts_sync <= 2'b11;
    else       cts_sync <= {cts_sync[0], cts_n};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= issue;
      if (issue) tx_data <= tx_head;
    end
  end

  // Full is judged on pre-cycle state, so a same-cycle pop does not save the byte.
  always_ff @(posedge clk) begin
    if (reset)                      rx_overflow <= 1'b0;
    else if (rx_strobe && rx_full)  rx_overflow <= 1'b1;
    else if (overflow_clear)        rx_overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) rts_n <= 1'b1;
    else       rts_n <= (rx_free <= RTS_LIMIT);
  end

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Self-checking bench for uart_stream_bridge: directed scenarios followed by
// randomized traffic, all compared every cycle against a queue-based model.
module tb_uart_stream_bridge;

  localparam int RXL    = 3;
  localparam int TXL    = 2;
  localparam int MARGIN = 2;
  localparam int RX_CAP = 1 << RXL;
  localparam int TX_CAP = 1 << TXL;

  logic           clk = 1'b0;
  logic           reset;
  logic           phy_reset;
  logic [7:0]     rx_data;
  logic           rx_strobe;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic           cts_n;
  logic           rts_n;
  logic [7:0]     in_data;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready;
  logic [RXL:0]   rx_count;
  logic [TXL:0]   tx_count;
  logic           rx_overflow;
  logic           overflow_clear;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model state
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit         m_ovf;
  bit         m_rts;
  bit         m_tx_start;
  logic [7:0] m_tx_data;
  bit         cts_d1, cts_d2;   // cts_n as seen one and two edges back

  // observed issue log
  int         start_cyc[$];
  logic [7:0] start_byte[$];

  always #5 clk = ~clk;

  uart_stream_bridge #(
    .RX_DEPTH_LOG2 (RXL),
    .TX_DEPTH_LOG2 (TXL),
    .RTS_MARGIN    (MARGIN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .phy_reset      (phy_reset),
    .rx_data        (rx_data),
    .rx_strobe      (rx_strobe),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .tx_busy        (tx_busy),
    .cts_n          (cts_n),
    .rts_n          (rts_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .rx_count       (rx_count),
    .tx_count       (tx_count),
    .rx_overflow    (rx_overflow),
    .overflow_clear (overflow_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_ovf      = 1'b0;
    m_rts      = 1'b1;
    m_tx_start = 1'b0;
    m_tx_data  = 8'h00;
    cts_d1     = 1'b1;
    cts_d2     = 1'b1;
  endtask

  // Compare outputs mid-cycle, advance the model over the coming edge,
  // then return just after that edge so the caller can drive new inputs.
  task automatic one_cycle();
    int  rxn;
    int  txn;
    bit  issue;
    @(negedge clk);
    check("phy_reset", phy_reset, reset);
    check("out_valid", out_valid, rxq.size() != 0);
    if (rxq.size() != 0) check("out_data", out_data, rxq[0]);
    check("rx_count", rx_count, rxq.size());
    check("tx_count", tx_count, txq.size());
    check("rx_overflow", rx_overflow, m_ovf);
    check("rts_n", rts_n, m_rts);
    check("in_ready", in_ready, !reset && txq.size() < TX_CAP);
    check("tx_start", tx_start, m_tx_start);
    check("tx_data", tx_data, m_tx_data);
    if (tx_start === 1'b1) begin
      start_cyc.push_back(cyc);
      start_byte.push_back(tx_data);
    end
    if (reset) begin
      model_reset();
    end else begin
      rxn   = rxq.size();
      txn   = txq.size();
      m_rts = (RX_CAP - rxn) <= MARGIN;
      if (rx_strobe && rxn == RX_CAP) m_ovf = 1'b1;
      else if (overflow_clear)        m_ovf = 1'b0;
      if (out_ready && rxn > 0)       void'(rxq.pop_front());
      if (rx_strobe && rxn < RX_CAP)  rxq.push_back(rx_data);
      issue      = txn > 0 && !tx_busy && !cts_d2 && !m_tx_start;
      m_tx_start = issue;
      if (issue) m_tx_data = txq.pop_front();
      if (in_valid && txn < TX_CAP)   txq.push_back(in_data);
      cts_d2 = cts_d1;
      cts_d1 = cts_n;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int  n0;
    bit  seen;
    reset          = 1'b1;
    rx_data        = 8'h00;
    rx_strobe      = 1'b0;
    tx_busy        = 1'b0;
    cts_n          = 1'b1;
    in_data        = 8'h00;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    overflow_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    one_cycle();              // outputs while reset is held
    reset = 1'b0;
    repeat (2) one_cycle();   // rts_n drops after the first free-running edge

    // RX pass-through 0x41..0x43 with the core always ready
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data   = 8'h41 + 8'(i);
      rx_strobe = 1'b1;
      one_cycle();
    end
    rx_strobe = 1'b0;
    repeat (3) one_cycle();

    // fill past capacity, rts_n near full, clear racing a dropped byte
    out_ready = 1'b0;
    for (int i = 0; i < RX_CAP + 1; i++) begin
      rx_data   = 8'($urandom);
      rx_strobe = 1'b1;
      one_cycle();
    end
    overflow_clear = 1'b1;
    one_cycle();              // set wins over clear
    rx_strobe = 1'b0;
    one_cycle();              // clear alone takes effect
    overflow_clear = 1'b0;
    out_ready = 1'b1;
    repeat (RX_CAP + 2) one_cycle();
    out_ready = 1'b0;

    // two bytes through TX with the PHY idle
    cts_n = 1'b0;
    repeat (3) one_cycle();
    n0 = start_byte.size();
    in_valid = 1'b1;
    in_data  = 8'h10;
    one_cycle();
    in_data  = 8'h20;
    one_cycle();
    in_valid = 1'b0;
    repeat (6) one_cycle();
    check("tx_pair_count", start_byte.size() - n0, 2);
    if (start_byte.size() >= n0 + 2) begin
      check("tx_first", start_byte[n0], 8'h10);
      check("tx_second", start_byte[n0+1], 8'h20);
      check("tx_gap_ok", (start_cyc[n0+1] - start_cyc[n0]) >= 2, 1);
    end

    // CTS held off: queue fills, nothing issues, then release
    cts_n = 1'b1;
    repeat (3) one_cycle();
    in_valid = 1'b1;
    for (int i = 0; i < TX_CAP + 2; i++) begin
      in_data = 8'($urandom);
      one_cycle();
    end
    n0 = start_byte.size();
    repeat (4) one_cycle();
    check("cts_hold_none", start_byte.size() - n0, 0);
    check("cts_hold_full", tx_count, TX_CAP);
    cts_n = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      one_cycle();
      seen = start_byte.size() > n0;
    end
    check("cts_release_start", seen, 1);
    // keep streaming across pointer wraps
    for (int i = 0; i < 24; i++) begin
      in_data = 8'($urandom);
      one_cycle();
    end
    in_valid = 1'b0;
    repeat (12) one_cycle();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 499) == 0);
      rx_strobe      = ($urandom_range(0, 2) == 0);
      rx_data        = 8'($urandom);
      out_ready      = ($urandom_range(0, 2) != 0);
      in_valid       = ($urandom_range(0, 1) == 0);
      in_data        = 8'($urandom);
      tx_busy        = ($urandom_range(0, 3) == 0);
      overflow_clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) cts_n = ~cts_n;
      one_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
